// File: rtl/mpp_mem_arbiter.sv
// mpp_mem_arbiter: two-port round-robin arbiter and access sequencer for the
// single external 8-bit memory bus. One transfer is IDLE -> ACCESS (1 +
// WAIT_STATES cycles with chip select low) -> RECOVER (ack cycle, bus idle).
module mpp_mem_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] addr0,
  input  logic        we0,
  input  logic [7:0]  wdata0,
  input  logic        req1,
  input  logic [15:0] addr1,
  input  logic        we1,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_cs_n,
  output logic        mem_we_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        owner;
  logic        last_owner;
  logic        we_q;
  logic        any_req;
  logic        sel;

  // Round robin: a lone requester wins; on a tie the port that did not
  // win last time gets the bus.
  assign any_req = req0 | req1;
  assign sel     = (req0 & req1) ? ~last_owner : req1;
  assign busy    = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus datapath: latch the winner's request at grant, count wait states,
  // capture read data and pulse the owner's ack on the last ACCESS edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cs_n   <= 1'b1;
      mem_we_n   <= 1'b1;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 8'h00;
      rdata      <= 8'h00;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      cnt        <= 4'd0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= sel;
            last_owner <= sel;
            mem_addr   <= sel ? addr1 : addr0;
            mem_wdata  <= sel ? wdata1 : wdata0;
            we_q       <= sel ? we1 : we0;
            mem_cs_n   <= 1'b0;
            mem_we_n   <= ~(sel ? we1 : we0);
            cnt        <= 4'(WAIT_STATES);
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!we_q) rdata <= mem_rdata;
            ack0     <= ~owner;
            ack1     <= owner;
            mem_cs_n <= 1'b1;
            mem_we_n <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
